qbus_dma_arb: RTL and testbench
===============================

Name: qbus_dma_arb

Overview:
- Shares the vm3 processor bus among NREQ on-board DMA masters, for example a disk controller and a video fetcher.
- Drives the Q-bus DMA handshake on the processor side: dmr_n out, dmgo_n in, sack_n out.
- Passes each grant to exactly one internal requester, selected by round-robin.
- Sits in the board top between the vm3 pin group and the peripheral masters.
- Withdraws a grant that is never acknowledged and flags a timeout.

Parameters:
NREQ, 4, number of DMA requesters (2..8)
TGNT, 64, cycles allowed between gnt and ack before the grant is withdrawn
OWNW, 2, width of the owner index; equals clog2(NREQ)

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester bus request, active high, level
ack  in  NREQ  per-requester bus acquired; held high for the whole tenure
gnt  out  NREQ  one-hot grant, high from grant until ack or timeout
owner  out  OWNW  index of the current or pending winner
busy  out  1  arbiter not in IDLE
tout  out  1  one-cycle pulse on grant timeout
dmr_n  out  1  DMA request to the CPU, active low
dmgo_n  in  1  DMA grant from the CPU, asynchronous, active low
sack_n  out  1  DMA acknowledge to the CPU, active low
sync_n  in  1  bus address strobe monitor, asynchronous, active low

Behaviour:
- Reset (asynchronous, immediate):
  - gnt=0, dmr_n=1, sack_n=1, tout=0, busy=0, owner=0.
  - Round-robin pointer ptr=0, timer=0, state=IDLE.
  - Synchronizer flops are preset to 1.
- dmgo_n and sync_n each pass through a 2-FF synchronizer; the FSM sees only the synced copies (gos_n, syncs_n).
- All outputs are registered.
- IDLE:
  - If req!=0: winner = first set bit of req scanning from ptr upward, wrapping NREQ-1 -> 0.
  - On that edge: owner<=winner, dmr_n<=0, go REQ.
  - The winner is frozen until the next return to IDLE.
- REQ:
  - If req[owner]=0: dmr_n<=1, go WAITGO. No grant is issued; ptr is unchanged.
  - Else if gos_n=0 and syncs_n=1: gnt[owner]<=1, timer<=0, go GRANT.
  - A gos_n=0 with syncs_n=0 is held off until syncs_n=1.
- GRANT:
  - If ack[owner]=1: gnt<=0, sack_n<=0, dmr_n<=1, go OWN.
  - Else if timer=TGNT-1: gnt<=0, dmr_n<=1, tout<=1 for one cycle, ptr<=owner+1 (mod NREQ), go WAITGO.
  - Else timer increments.
  - ack and timeout in the same cycle: ack wins.
- OWN:
  - sack_n is held low while ack[owner]=1.
  - When ack[owner] falls: sack_n<=1, ptr<=owner+1 (mod NREQ), go WAITGO.
- WAITGO:
  - Wait for gos_n=1, i.e. the CPU has released its grant, then go IDLE.
  - This prevents a stale dmgo from being reused.
- Signals ignored:
  - ack bits of non-owners are ignored in every state.
  - Changes on req of non-owners have no effect outside IDLE.
- busy=1 in REQ, GRANT, OWN and WAITGO.
- gnt is never more than one-hot and is never asserted while sack_n=0.
- Latencies:
  - req rise -> dmr_n low: 1 cycle.
  - dmgo_n fall (with sync_n high) -> gnt: 3 cycles.
  - ack rise -> sack_n low: 1 cycle.
  - ack fall -> sack_n high: 1 cycle.
  - dmgo_n rise -> busy low: 3 cycles.
- Round-robin: after a tenure or timeout for owner k, ptr=k+1 and wraps at NREQ-1.

Test Plan:
- Single requester:
  - Stimulus: req=0001 -> dmr_n=0 next cycle. Drive dmgo_n=0 -> gnt=0001 after 3 cycles. Raise ack[0].
  - Response: next cycle sack_n=0, gnt=0000, dmr_n=1. Drop ack -> sack_n=1. Release dmgo_n -> busy=0 after 3 cycles.
- Round-robin:
  - Stimulus: req=1111 held. Each requester acks 2 cycles after gnt, holds 4 cycles, drops. CPU model grants dmgo_n 2 cycles after dmr_n.
  - Response: owner sequence 0,1,2,3,0,1.
- Timeout:
  - Stimulus: req=0100, grant issued, ack never asserted.
  - Response: gnt[2] stays high exactly 64 cycles; tout pulses once; dmr_n=1. With req=1100 held, the next owner is 3.
- Bus busy hold-off:
  - Stimulus: dmgo_n=0 while sync_n=0 for 10 cycles.
  - Response: no gnt during the hold-off; gnt appears 3 cycles after sync_n rises.
- Request withdrawal:
  - Stimulus: req[1] drops while in REQ.
  - Response: dmr_n=1 next cycle; gnt stays 0; returns to IDLE once dmgo_n is high; ptr is unchanged.
- Reset mid-OWN:
  - Stimulus: assert rst_n=0 while sack_n=0.
  - Response: sack_n=1, dmr_n=1, gnt=0, busy=0 without waiting for clk. After release, the first grant goes to the lowest set req bit (ptr=0).

Source files
------------

// File: rtl/qbus_dma_arb.sv
// qbus_dma_arb: round-robin arbiter sharing the Q-bus DMA handshake among NREQ on-board masters
module qbus_dma_arb #(
    parameter int NREQ = 4,
    parameter int TGNT = 64,
    parameter int OWNW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] ack,
    output logic [NREQ-1:0] gnt,
    output logic [OWNW-1:0] owner,
    output logic            busy,
    output logic            tout,
    output logic            dmr_n,
    input  logic            dmgo_n,
    output logic            sack_n,
    input  logic            sync_n
);
    localparam int TW = $clog2(TGNT + 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] GRANT  = 3'd2;
    localparam logic [2:0] OWN    = 3'd3;
    localparam logic [2:0] WAITGO = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [OWNW-1:0] owner_q, owner_d, ptr_q, ptr_d, win, idx, nxt;
    logic [TW-1:0]   timer_q, timer_d;
    logic            busy_q, busy_d, tout_q, tout_d, dmr_n_q, dmr_n_d, sack_n_q, sack_n_d;
    logic            go_meta_q, gos_n_q, sy_meta_q, syncs_n_q;

    // two-flop synchronizers for the asynchronous CPU grant and bus strobe, idle high
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {go_meta_q, gos_n_q, sy_meta_q, syncs_n_q} <= 4'b1111;
        else {go_meta_q, gos_n_q, sy_meta_q, syncs_n_q} <= {dmgo_n, go_meta_q, sync_n, sy_meta_q};

    // round-robin pick: first requester at or above ptr, wrapping; lowest offset wins
    always_comb begin
        win = ptr_q;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = OWNW'((int'(ptr_q) + i) % NREQ);
            if (req[idx]) win = idx;
        end
    end

    assign nxt = (owner_q == OWNW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // handshake FSM: request the bus, hand the CPU grant to the owner, track its tenure
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        tout_d   = 1'b0;
        dmr_n_d  = dmr_n_q;
        sack_n_d = sack_n_q;
        case (state_q)
            IDLE:
                if (|req) begin
                    owner_d = win;
                    dmr_n_d = 1'b0;
                    state_d = REQ;
                end
            REQ:
                if (!req[owner_q]) begin
                    dmr_n_d = 1'b1;
                    state_d = WAITGO;
                end else if (!gos_n_q && syncs_n_q) begin
                    gnt_d   = NREQ'(1) << owner_q;
                    timer_d = '0;
                    state_d = GRANT;
                end
            GRANT:
                if (ack[owner_q]) begin
                    gnt_d    = '0;
                    sack_n_d = 1'b0;
                    dmr_n_d  = 1'b1;
                    state_d  = OWN;
                end else if (timer_q == TW'(TGNT - 1)) begin
                    gnt_d   = '0;
                    dmr_n_d = 1'b1;
                    tout_d  = 1'b1;
                    ptr_d   = nxt;
                    state_d = WAITGO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            OWN:
                if (!ack[owner_q]) begin
                    sack_n_d = 1'b1;
                    ptr_d    = nxt;
                    state_d  = WAITGO;
                end
            WAITGO:
                if (gos_n_q) state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            timer_q  <= '0;
            busy_q   <= 1'b0;
            tout_q   <= 1'b0;
            dmr_n_q  <= 1'b1;
            sack_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            busy_q   <= busy_d;
            tout_q   <= tout_d;
            dmr_n_q  <= dmr_n_d;
            sack_n_q <= sack_n_d;
        end

    assign gnt    = gnt_q;
    assign owner  = owner_q;
    assign busy   = busy_q;
    assign tout   = tout_q;
    assign dmr_n  = dmr_n_q;
    assign sack_n = sack_n_q;
endmodule

// File: tb/tb_qbus_dma_arb.sv
// tb_qbus_dma_arb: randomized episodes against a round-robin reference model with a grant scoreboard
module tb_qbus_dma_arb;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] ack = '0;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy, tout, dmr_n, sack_n;
    logic       dmgo_n = 1'b1;
    logic       sync_n = 1'b1;
    logic [3:0] gnt_prev = '0;
    int n_chk = 0, n_fail = 0, ptr_m = 0, tout_exp = 0, tout_obs = 0, e = 0;
    int exp_q[$];

    qbus_dma_arb #(.NREQ(4), .TGNT(64), .OWNW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .gnt(gnt), .owner(owner),
        .busy(busy), .tout(tout), .dmr_n(dmr_n), .dmgo_n(dmgo_n), .sack_n(sack_n), .sync_n(sync_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference: first requester at or after p, wrapping
    function automatic int rr_pick(input int p, input logic [3:0] m);
        for (int k = 0; k < 4; k++)
            if (((m >> ((p + k) % 4)) & 4'b1) != 0) return (p + k) % 4;
        return -1;
    endfunction

    // mode 0: normal tenure, 1: timeout, 2: request withdrawal, 3: reset during tenure
    task automatic episode(input logic [3:0] m, input int mode, input int hold);
        int w, cnt, d;
        logic [3:0] bw;
        w  = rr_pick(ptr_m, m);
        bw = 4'b1 << w;
        req = m;
        step();
        chk("req_dmr_low", int'(dmr_n), 0);
        chk("req_owner", int'(owner), w);
        chk("req_busy", int'(busy), 1);
        if (mode == 2) begin
            req = m & ~bw;
            step();
            chk("wd_dmr_high", int'(dmr_n), 1);
            chk("wd_gnt", int'(gnt), 0);
            chk("wd_busy", int'(busy), 1);
            req = '0;
            step();
            chk("wd_idle", int'(busy), 0);
            return;
        end
        exp_q.push_back(w);
        dmgo_n = 1'b0;
        sync_n = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            req = (4'($urandom) & ~bw) | bw;
            step();
            chk("holdoff_gnt", int'(gnt), 0);
        end
        sync_n = 1'b1;
        cnt = 0;
        do begin step(); cnt++; end while (gnt == 0 && cnt < 10);
        chk("gnt_latency", cnt, 3);
        if (mode == 1) begin
            cnt = 0;
            do begin
                ack = 4'($urandom) & ~bw;
                step();
                cnt++;
            end while (gnt != 0 && cnt < 100);
            chk("gnt_width", cnt, 64);
            chk("tout_pulse", int'(tout), 1);
            chk("tout_dmr_high", int'(dmr_n), 1);
            tout_exp++;
            ack = '0;
            step();
            chk("tout_clear", int'(tout), 0);
        end else begin
            d = $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                ack = 4'($urandom) & ~bw;
                step();
            end
            ack = bw;
            step();
            chk("ack_sack_low", int'(sack_n), 0);
            chk("ack_gnt_clear", int'(gnt), 0);
            chk("ack_dmr_high", int'(dmr_n), 1);
            if (mode == 3) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_sack", int'(sack_n), 1);
                chk("rst_dmr", int'(dmr_n), 1);
                chk("rst_gnt", int'(gnt), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_owner", int'(owner), 0);
                req = '0; ack = '0; dmgo_n = 1'b1; sync_n = 1'b1;
                #3 rst_n = 1'b1;
                step();
                ptr_m = 0;
                return;
            end
            d = $urandom_range(1, 4);
            for (int i = 0; i < d; i++) begin
                ack = bw | (4'($urandom) & ~bw);
                step();
                chk("own_sack_held", int'(sack_n), 0);
            end
            ack = 4'($urandom) & ~bw;
            step();
            chk("drop_sack_high", int'(sack_n), 1);
            ack = '0;
        end
        ptr_m = (w + 1) % 4;
        req = '0;
        dmgo_n = 1'b1;
        cnt = 0;
        do begin step(); cnt++; end while (busy && cnt < 10);
        chk("idle_latency", cnt, 3);
    endtask

    // monitor: grant scoreboard, one-hot and sack exclusion, timeout pulses
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("gnt_onehot", int'($countones(gnt) <= 1), 1);
            chk("gnt_with_sack", int'(gnt != 0 && !sack_n), 0);
            if (gnt != 0 && gnt_prev == 0) begin
                if (exp_q.size() == 0) chk("gnt_unexpected", int'(gnt), 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_gnt", int'(gnt), 1 << e);
                    chk("sb_owner", int'(owner), e);
                end
            end
            if (tout) tout_obs++;
        end
        gnt_prev = gnt;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("init_gnt", int'(gnt), 0);
        chk("init_dmr", int'(dmr_n), 1);
        chk("init_sack", int'(sack_n), 1);
        chk("init_busy", int'(busy), 0);
        chk("init_tout", int'(tout), 0);
        chk("init_owner", int'(owner), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 6; i++) episode(4'b1111, 0, 0);
        episode(4'b0001, 0, 0);
        episode(4'b0001, 0, 10);
        episode(4'b0100, 1, 0);
        episode(4'b1100, 0, 0);
        episode(4'b0010, 2, 0);
        episode(4'b0110, 0, 0);
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 5);
            episode(4'($urandom_range(1, 15)), (r == 5) ? 2 : (r == 4) ? 1 : 0,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0);
        end
        episode(4'b1000, 3, 0);
        episode(4'b1010, 0, 0);
        step();
        step();
        chk("sb_drained", exp_q.size(), 0);
        chk("tout_count", tout_obs, tout_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
